// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported multi-cycle memory between a fetch port and a data port.
// Optional macro ARB_RR_EN selects round-robin arbitration; otherwise the data port has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              own_q, own_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_req;
  logic              grant_dm;

  assign dm_req = dm_rd | dm_wr;

`ifdef ARB_RR_EN
  logic last_q, last_d;
  // On contention the port that did not win the most recent grant goes first.
  assign grant_dm = dm_req & ~(if_req & last_q);
`else
  assign grant_dm = dm_req;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_d      = own_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          own_d   = 1'b1;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          we_d    = dm_wr;
          cnt_d   = CNT_INIT;
          state_d = ACC;
`ifdef ARB_RR_EN
          last_d  = 1'b1;
`endif
        end else if (if_req) begin
          own_d   = 1'b0;
          addr_d  = if_addr;
          we_d    = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = ACC;
`ifdef ARB_RR_EN
          last_d  = 1'b0;
`endif
        end
      end
      ACC: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (own_q) dm_rdata_d = ram_rdata;
            else       if_rdata_d = ram_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      own_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_q      <= own_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  // Address and data come straight from registers, so they are stable throughout ACC.
  assign ram_en    = (state_q == ACC);
  assign ram_we    = (state_q == ACC) & we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign if_ack    = (state_q == RESP) & ~own_q;
  assign dm_ack    = (state_q == RESP) & own_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = (state_q != IDLE);
  assign stall_if  = if_req & ~if_ack;
  assign stall_dm  = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: a MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_rd, dm_wr;
  logic [7:0]  if_addr, dm_addr, ram_addr;
  logic [31:0] dm_wdata, if_rdata, dm_rdata, ram_wdata, ram_rdata;
  logic        if_ack, dm_ack, stall_if, stall_dm, ram_en, ram_we, busy;

  logic        u1_if_req;
  logic [7:0]  u1_if_addr, u1_ram_addr;
  logic [31:0] u1_if_rdata, u1_dm_rdata, u1_ram_wdata, u1_ram_rdata;
  logic        u1_if_ack, u1_dm_ack, u1_stall_if, u1_stall_dm, u1_ram_en, u1_ram_we, u1_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cycles = 0;
  logic [7:0]  last_wr_addr = 8'h00;
  logic [31:0] last_wr_data = 32'h0;

  always #5 clk = ~clk;

  // Memory model: fixed contents for the addresses the bench reads.
  always_comb begin
    case (ram_addr)
      8'h04:   ram_rdata = 32'h2002000A;
      8'h08:   ram_rdata = 32'hCAFEF00D;
      default: ram_rdata = 32'hC0DE0000 | {24'h0, ram_addr};
    endcase
  end
  assign u1_ram_rdata = 32'hA5000000 | {24'h0, u1_ram_addr};

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      wr_cycles    <= wr_cycles + 1;
      last_wr_addr <= ram_addr;
      last_wr_data <= ram_wdata;
    end
  end

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset),
    .if_req(u1_if_req), .if_addr(u1_if_addr), .if_rdata(u1_if_rdata), .if_ack(u1_if_ack),
    .dm_rd(1'b0), .dm_wr(1'b0), .dm_addr(8'h00), .dm_wdata(32'h0),
    .dm_rdata(u1_dm_rdata), .dm_ack(u1_dm_ack),
    .stall_if(u1_stall_if), .stall_dm(u1_stall_dm),
    .ram_en(u1_ram_en), .ram_we(u1_ram_we), .ram_addr(u1_ram_addr), .ram_wdata(u1_ram_wdata),
    .ram_rdata(u1_ram_rdata), .busy(u1_busy)
  );

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_ctl: got en=%b we=%b want 0 0", ram_en, ram_we); end
    n_checks++; if (ram_addr !== 8'h00 || ram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_ram_bus: got addr=%h wdata=%h want 0 0", ram_addr, ram_wdata); end
    n_checks++; if (if_ack !== 1'b0 || dm_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks: got %b %b want 0 0", if_ack, dm_ack); end
    n_checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata, dm_rdata); end
    n_checks++; if (u1_busy !== 1'b0 || u1_ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_lat1: got busy=%b en=%b want 0 0", u1_busy, u1_ram_en); end
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h04;
    #1;
    n_checks++; if (stall_if !== 1'b1 || ram_en !== 1'b0) begin n_fail++; $display("FAIL fetch_c0: got stall_if=%b ram_en=%b want 1 0", stall_if, ram_en); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        n_checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h04) begin n_fail++; $display("FAIL fetch_acc%0d: got en=%b we=%b addr=%h want 1 0 04", k, ram_en, ram_we, ram_addr); end
        n_checks++; if (stall_if !== 1'b1 || if_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_stall%0d: got stall=%b ack=%b want 1 0", k, stall_if, if_ack); end
      end else begin
        n_checks++; if (if_ack !== 1'b1 || ram_en !== 1'b0) begin n_fail++; $display("FAIL fetch_ack: got ack=%b en=%b want 1 0", if_ack, ram_en); end
        n_checks++; if (if_rdata !== 32'h2002000A) begin n_fail++; $display("FAIL fetch_rdata: got %h want 2002000a", if_rdata); end
        n_checks++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL fetch_stall3: got %b want 0", stall_if); end
        if_req = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || if_ack !== 1'b0 || if_rdata !== 32'h2002000A) begin n_fail++; $display("FAIL fetch_after: got busy=%b ack=%b rdata=%h want 0 0 2002000a", busy, if_ack, if_rdata); end
  endtask

  task automatic test_read();
    @(negedge clk);
    dm_rd = 1'b1; dm_addr = 8'h08;
    #1;
    n_checks++; if (stall_dm !== 1'b1) begin n_fail++; $display("FAIL read_stall0: got %b want 1", stall_dm); end
    repeat (3) @(negedge clk);
    n_checks++; if (dm_ack !== 1'b1 || if_ack !== 1'b0 || dm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL read_ack: got ack=%b if_ack=%b rdata=%h want 1 0 cafef00d", dm_ack, if_ack, dm_rdata); end
    dm_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    int w0;
    w0 = wr_cycles;
    @(negedge clk);
    dm_wr = 1'b1; dm_addr = 8'h10; dm_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        n_checks++; if (ram_we !== 1'b1 || ram_wdata !== 32'hDEADBEEF || ram_addr !== 8'h10) begin n_fail++; $display("FAIL write_acc%0d: got we=%b wdata=%h addr=%h want 1 deadbeef 10", k, ram_we, ram_wdata, ram_addr); end
        n_checks++; if (dm_ack !== 1'b0) begin n_fail++; $display("FAIL write_early_ack%0d: got %b want 0", k, dm_ack); end
      end else begin
        n_checks++; if (dm_ack !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL write_ack: got ack=%b we=%b want 1 0", dm_ack, ram_we); end
        n_checks++; if (dm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL write_rdata_held: got %h want cafef00d", dm_rdata); end
        dm_wr = 1'b0;
      end
    end
    n_checks++; if (wr_cycles - w0 != 2 || last_wr_addr !== 8'h10 || last_wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_mem: got cycles=%0d addr=%h data=%h want 2 10 deadbeef", wr_cycles - w0, last_wr_addr, last_wr_data); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int ack_dm_k, ack_if_k;
`ifdef ARB_RR_EN
    ack_if_k = 3; ack_dm_k = 7;
`else
    ack_dm_k = 3; ack_if_k = 7;
`endif
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h04; dm_rd = 1'b1; dm_addr = 8'h08;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk); else #1;
      n_checks++; if (if_ack !== (k == ack_if_k) || dm_ack !== (k == ack_dm_k)) begin n_fail++; $display("FAIL cont_acks_c%0d: got if=%b dm=%b want %b %b", k, if_ack, dm_ack, k == ack_if_k, k == ack_dm_k); end
      n_checks++; if (stall_if !== (k < ack_if_k) || stall_dm !== (k < ack_dm_k)) begin n_fail++; $display("FAIL cont_stalls_c%0d: got if=%b dm=%b want %b %b", k, stall_if, stall_dm, k < ack_if_k, k < ack_dm_k); end
      if (k == ack_if_k) begin
        n_checks++; if (if_rdata !== 32'h2002000A) begin n_fail++; $display("FAIL cont_if_rdata: got %h want 2002000a", if_rdata); end
        if_req = 1'b0;
      end
      if (k == ack_dm_k) begin
        n_checks++; if (dm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL cont_dm_rdata: got %h want cafef00d", dm_rdata); end
        dm_rd = 1'b0;
      end
    end
  endtask

  task automatic test_rd_wr_both();
    int w0;
    w0 = wr_cycles;
    @(negedge clk);
    dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 8'h20; dm_wdata = 32'h12345678;
    @(negedge clk);
    n_checks++; if (ram_we !== 1'b1 || ram_addr !== 8'h20) begin n_fail++; $display("FAIL both_we: got we=%b addr=%h want 1 20", ram_we, ram_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL both_ack: got ack=%b rdata=%h want 1 cafef00d", dm_ack, dm_rdata); end
    dm_rd = 1'b0; dm_wr = 1'b0;
    @(negedge clk);
    n_checks++; if (dm_ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL both_single_ack: got ack=%b busy=%b want 0 0", dm_ack, busy); end
    n_checks++; if (wr_cycles - w0 != 2 || last_wr_data !== 32'h12345678) begin n_fail++; $display("FAIL both_mem: got cycles=%0d data=%h want 2 12345678", wr_cycles - w0, last_wr_data); end
  endtask

  task automatic test_reset_mid_acc();
    @(negedge clk);
    dm_rd = 1'b1; dm_addr = 8'h08;
    @(negedge clk);
    n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_inacc: got ram_en=%b want 1", ram_en); end
    reset = 1'b0;
    #1;
    n_checks++; if (ram_en !== 1'b0 || busy !== 1'b0 || dm_ack !== 1'b0 || ram_addr !== 8'h00) begin n_fail++; $display("FAIL rst_mid_outs: got en=%b busy=%b ack=%b addr=%h want 0 0 0 00", ram_en, busy, dm_ack, ram_addr); end
    n_checks++; if (dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h %h want 0 0", dm_rdata, if_rdata); end
    repeat (2) @(negedge clk);
    n_checks++; if (dm_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_noack: got %b want 0", dm_ack); end
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++; if (ram_en !== (k < 3) || dm_ack !== (k == 3)) begin n_fail++; $display("FAIL rst_regrant_c%0d: got en=%b ack=%b want %b %b", k, ram_en, dm_ack, k < 3, k == 3); end
    end
    n_checks++; if (dm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_regrant_rdata: got %h want cafef00d", dm_rdata); end
    dm_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back_lat1();
    @(negedge clk);
    u1_if_req = 1'b1; u1_if_addr = 8'h30;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_checks++; if (u1_ram_en !== (k % 3 == 1) || u1_if_ack !== (k % 3 == 2)) begin n_fail++; $display("FAIL lat1_c%0d: got en=%b ack=%b want %b %b", k, u1_ram_en, u1_if_ack, k % 3 == 1, k % 3 == 2); end
      if (k % 3 == 2) begin
        n_checks++; if (u1_if_rdata !== (32'hA5000000 | {24'h0, u1_if_addr})) begin n_fail++; $display("FAIL lat1_rdata_c%0d: got %h want %h", k, u1_if_rdata, 32'hA5000000 | {24'h0, u1_if_addr}); end
        u1_if_addr = u1_if_addr + 8'h01;
      end
    end
    u1_if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = 8'h00;
    dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = 8'h00; dm_wdata = 32'h0;
    u1_if_req = 1'b0; u1_if_addr = 8'h00;
    test_reset();
    test_fetch();
    test_read();
    test_write();
    test_contention();
    test_rd_wr_both();
    test_reset_mid_acc();
    test_back_to_back_lat1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
